// File: rtl/cereal_pkg.sv
// Shared types and constants for the cereal_tx serial transmitter.
package cereal_pkg;

    // Frame sequencer states.
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Parity mode encodings for the PARITY parameter.
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Number of bit times in one frame: start + payload + optional parity + stop bits.
    function automatic int frame_bits(input int data_w, input int parity, input int stop_bits);
        return 1 + data_w + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/cereal_baud_gen.sv
// Bit-time generator: counts sysclk cycles while enabled and pulses tick
// on the last cycle of each bit period.
module cereal_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic sysclk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && (cnt_q == CNT_MAX);

    // Next count: hold at zero while disabled, wrap to zero at terminal count.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en || tick) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cereal_tx.sv
// Parametrised asynchronous serial transmitter: start bit, DATA_W payload
// bits (LSB or MSB first), optional parity, 1 or 2 stop bits.
module cereal_tx
    import cereal_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int LSB_FIRST    = 1,
    parameter int START_EDGE   = 1
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              cereal
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    // Reject configurations the frame sequencer cannot produce.
    if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
        $fatal(1, "cereal_tx: PARITY must be 0 (none), 1 (even) or 2 (odd)");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $fatal(1, "cereal_tx: STOP_BITS must be 1 or 2");
    end
    if (DATA_W < 5 || DATA_W > 16) begin : g_bad_width
        $fatal(1, "cereal_tx: DATA_W must be in 5..16");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_rate
        $fatal(1, "cereal_tx: CLKS_PER_BIT must be at least 2");
    end

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              parity_q, parity_d;
    logic              start_q;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cereal_q, cereal_d;
    logic              tick;
    logic              baud_en;
    logic              accept;

    assign baud_en = (state_q != S_IDLE);

    cereal_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .sysclk (sysclk),
        .reset  (reset),
        .en     (baud_en),
        .tick   (tick)
    );

    // A request is only honoured in IDLE; edge mode needs a fresh rising edge.
    assign accept = (state_q == S_IDLE) && start && ((START_EDGE == 0) || !start_q);

    // Sequencer next state; the line value is derived from the state being
    // entered so that cereal, busy and done all come straight from flops.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        idx_d    = idx_q;
        parity_d = parity_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_START;
                    shreg_d  = data;
                    idx_d    = '0;
                    parity_d = (^data) ^ (PARITY == PAR_ODD);
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shreg_d = (LSB_FIRST != 0) ? (shreg_q >> 1) : (shreg_q << 1);
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_START:  cereal_d = 1'b0;
            S_DATA:   cereal_d = (LSB_FIRST != 0) ? shreg_d[0] : shreg_d[DATA_W-1];
            S_PARITY: cereal_d = parity_d;
            default:  cereal_d = 1'b1;
        endcase
    end

    // All sequencer state and registered outputs; reset parks the line high.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            idx_q    <= '0;
            parity_q <= 1'b0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cereal_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            idx_q    <= idx_d;
            parity_q <= parity_d;
            start_q  <= start;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cereal_q <= cereal_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign cereal = cereal_q;

endmodule

// File: tb/tb_cereal_tx.sv
// Self-checking bench for cereal_tx: five instances with different frame
// formats share one stimulus stream; each has its own expected-word queue
// and a per-cycle line monitor.
module tb_cereal_tx;

    localparam int NI  = 5;
    localparam int CPB = 4;

    // Per-instance configuration: 0 plain, 1 even parity, 2 odd parity,
    // 3 MSB first + 2 stop bits, 4 level-triggered start.
    localparam int P_PAR  [NI] = '{0, 1, 2, 0, 0};
    localparam int P_STOP [NI] = '{1, 1, 1, 2, 1};
    localparam int P_LSB  [NI] = '{1, 1, 1, 0, 1};
    localparam int P_EDGE [NI] = '{1, 1, 1, 1, 0};

    logic          sysclk = 1'b0;
    logic          reset;
    logic [7:0]    data;
    logic          start;
    logic [NI-1:0] busy_w;
    logic [NI-1:0] done_w;
    logic [NI-1:0] cereal_w;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q [NI][$];

    always #5 sysclk = ~sysclk;

    task automatic chk1(input string tag, input int inst, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s inst%0d: observed=%0b expected=%0b", tag, inst, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int inst, input int obs, input int exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_bad++;
            $error("FAIL %s inst%0d: observed=%0d expected=%0d", tag, inst, obs, exp);
        end
    endtask

    // Reference frame: bit k of the result is the line value during bit time k.
    function automatic logic [31:0] model(input logic [7:0] d, input int par, input int stops,
                                          input int lsb, output int nb);
        logic [31:0] f;
        int          k;
        f    = '1;
        f[0] = 1'b0;
        k    = 1;
        for (int i = 0; i < 8; i++) begin
            f[k] = (lsb != 0) ? d[i] : d[7-i];
            k++;
        end
        if (par != 0) begin
            f[k] = (par == 2) ? ~(^d) : (^d);
            k++;
        end
        nb = k + stops;
        return f;
    endfunction

    task automatic push_all(input logic [7:0] d);
        for (int i = 0; i < NI; i++) begin
            exp_q[i].push_back(d);
        end
    endtask

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        cereal_tx #(
            .DATA_W       (8),
            .CLKS_PER_BIT (CPB),
            .PARITY       (P_PAR[gi]),
            .STOP_BITS    (P_STOP[gi]),
            .LSB_FIRST    (P_LSB[gi]),
            .START_EDGE   (P_EDGE[gi])
        ) u_dut (
            .sysclk (sysclk),
            .reset  (reset),
            .data   (data),
            .start  (start),
            .busy   (busy_w[gi]),
            .done   (done_w[gi]),
            .cereal (cereal_w[gi])
        );

        // pos: -1 idle, -2 discarding an unexpected frame, >=0 cycle within frame.
        int          pos = -1;
        int          nb;
        logic [31:0] fbits;
        logic [7:0]  cur;

        initial begin
            forever begin
                @(posedge sysclk);
                #1;
                if (reset) begin
                    pos = -1;
                end else if (pos == -2) begin
                    if (!busy_w[gi]) pos = -1;
                end else begin
                    if (pos == -1) begin
                        if (busy_w[gi]) begin
                            chkn("frame_pending", gi, exp_q[gi].size(), (exp_q[gi].size() > 0) ? exp_q[gi].size() : 1);
                            if (exp_q[gi].size() == 0) begin
                                pos = -2;
                            end else begin
                                cur   = exp_q[gi].pop_front();
                                fbits = model(cur, P_PAR[gi], P_STOP[gi], P_LSB[gi], nb);
                                pos   = 0;
                            end
                        end else begin
                            chk1("idle_done", gi, done_w[gi], 1'b0);
                            chk1("idle_line", gi, cereal_w[gi], 1'b1);
                        end
                    end
                    if (pos >= 0) begin
                        if (pos < nb * CPB) begin
                            chk1("busy", gi, busy_w[gi], 1'b1);
                            chk1("line_bit", gi, cereal_w[gi], fbits[pos / CPB]);
                            chk1("inframe_done", gi, done_w[gi], 1'b0);
                            pos++;
                        end else begin
                            chk1("done_pulse", gi, done_w[gi], 1'b1);
                            chk1("busy_end", gi, busy_w[gi], 1'b0);
                            chk1("line_end", gi, cereal_w[gi], 1'b1);
                            $display("inst%0d frame data=%02h bits=%0d finished", gi, cur, nb);
                            pos = -1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        data  = 8'h00;
        repeat (3) @(negedge sysclk);
        for (int i = 0; i < NI; i++) begin
            chk1("rst_line", i, cereal_w[i], 1'b1);
            chk1("rst_busy", i, busy_w[i], 1'b0);
            chk1("rst_done", i, done_w[i], 1'b0);
        end
        reset = 1'b0;

        // Basic frame / parity / MSB-first+2 stop, single start pulse.
        @(negedge sysclk);
        data = 8'h5A;
        push_all(8'h5A);
        start = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
        repeat (cereal_pkg::frame_bits(8, 2, 2) * CPB + 10) @(negedge sysclk);

        // Start pulse and new data while busy are ignored.
        data = 8'hC1;
        push_all(8'hC1);
        start = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
        repeat (15) @(negedge sysclk);
        data  = 8'hFF;
        start = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
        repeat (60) @(negedge sysclk);

        // Start held high: one frame in edge mode, back-to-back frames in level mode.
        for (int c = 0; c < 300; c++) begin
            @(negedge sysclk);
            data  = 8'(8'h30 + (c + 21) / 41);
            start = 1'b1;
            if (c == 0) begin
                for (int i = 0; i < NI - 1; i++) exp_q[i].push_back(data);
            end
            if (c % 41 == 0) exp_q[4].push_back(data);
        end
        @(negedge sysclk);
        start = 1'b0;
        repeat (80) @(negedge sysclk);

        // Reset during data bit 3.
        data = 8'hA5;
        push_all(8'hA5);
        start = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
        repeat (17) @(negedge sysclk);
        #1 reset = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk1("midrst_line", i, cereal_w[i], 1'b1);
            chk1("midrst_busy", i, busy_w[i], 1'b0);
            chk1("midrst_done", i, done_w[i], 1'b0);
        end
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        for (int i = 0; i < NI; i++) exp_q[i].delete();

        // Clean frame after reset.
        @(negedge sysclk);
        data = 8'h3C;
        push_all(8'h3C);
        start = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
        repeat (60) @(negedge sysclk);

        for (int i = 0; i < NI; i++) begin
            chkn("frames_left", i, exp_q[i].size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cereal_tx.md
Name: cereal_tx

Overview:
- Parametrised serial transmitter; next generation of the fixed 8-bit `cereal` serializer.
- Converts a parallel word into an asynchronous serial frame on `cereal`: start bit, data, optional parity, 1 or 2 stop bits.
- Bit rate is configurable, bit order is selectable, and a start/busy/done handshake is provided.
- Sits between a parallel producer and an off-chip serial line, clocked from the 50 MHz `sysclk`.

Parameters:
- DATA_W, 8: payload bits per frame, range 5..16.
- CLKS_PER_BIT, 434: `sysclk` cycles per serial bit (434 gives 115200 baud at 50 MHz); must be >= 2.
- PARITY, 0: parity mode; 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- LSB_FIRST, 1: 1 = data bit 0 sent first; 0 = MSB first.
- START_EDGE, 1: 1 = frame triggered by a rising edge of `start`; 0 = level-triggered, so holding `start` high streams frames back to back.

Ports:
- sysclk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- data  in  DATA_W  payload; sampled only on the accept cycle.
- start  in  1  frame request.
- busy  out  1  high while a frame is in flight.
- done  out  1  one-cycle pulse when the last stop bit completes.
- cereal  out  1  serial line; idles high.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, cereal = 1, busy = 0, done = 0.
  - Baud counter, bit index and shift register all cleared.
  - Edge-detect register cleared to 0, so a `start` already high when reset deasserts counts as an edge.
- Accept condition (state IDLE):
  - START_EDGE=1: start & ~start_q.
  - START_EDGE=0: start.
  - `start` is ignored in every other state; edges seen while busy are not queued.
- Accept cycle N:
  - data is latched into the shift register.
  - Parity is computed from the latched word: even = XOR of bits, odd = inverted XOR.
  - Next state is START.
- Latency: at N+1, cereal = 0 and busy = 1 (all outputs registered).
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - Terminal count produces a bit tick, advances the bit or state, and reloads the counter to 0.
  - Every bit lasts exactly CLKS_PER_BIT cycles.
- Frame sequence:
  - START: drive 0.
  - DATA: DATA_W bits, in the order set by LSB_FIRST.
  - PARITY: only if PARITY != 0.
  - STOP: drive 1 for STOP_BITS bit times.
- Transitions:
  - IDLE -> START on accept.
  - START -> DATA on tick.
  - DATA -> PARITY or STOP on tick when bit index = DATA_W-1.
  - PARITY -> STOP on tick.
  - STOP -> IDLE on tick when stop count = STOP_BITS-1.
- Frame length = (1 + DATA_W + (PARITY != 0) + STOP_BITS) × CLKS_PER_BIT cycles, measured from N+1.
- Leaving STOP:
  - done = 1 for exactly one cycle.
  - busy = 0 in that same cycle; cereal stays 1.
- Level mode (START_EDGE=0) with start held high: the next accept occurs in the first IDLE cycle, giving exactly one idle-high cycle between frames.
- `data` changes while busy have no effect on the frame in flight.
- Reset mid-frame: the line returns to 1 immediately (asynchronous); no done pulse; the partial frame is abandoned.
- Parameters are checked at elaboration; illegal PARITY or STOP_BITS values cause a fatal error.

Decomposition:
- Shared package `cereal_pkg`:
  - state enum {IDLE, START, DATA, PARITY, STOP}.
  - Parity mode constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
  - Function returning the frame length in bits.
- One sub-module, `cereal_baud_gen`:
  - Parameter CLKS_PER_BIT; inputs sysclk, reset, en.
  - Output tick, a one-cycle pulse at terminal count.
  - Counter clears when en=0.
- The FSM, shift register and parity logic live in `cereal_tx`.

Test Plan:
- Basic frame, defaults except CLKS_PER_BIT=4:
  - Stimulus: data=8'h5A, single start pulse.
  - Required: cereal carries 0, then 0,1,0,1,1,0,1,0, then 1, each bit 4 cycles; busy high for exactly 40 cycles; one done pulse at cycle 41 after accept.
- Parity, PARITY=1 (even) then 2 (odd), data=8'h5A:
  - Required: parity bit 0 for even, 1 for odd.
  - Frame is 44 cycles at CLKS_PER_BIT=4.
- MSB first with two stop bits, LSB_FIRST=0, STOP_BITS=2, data=8'hC1:
  - Required data bits 1,1,0,0,0,0,0,1; stop high for 8 cycles before done.
- Start held high for 300 cycles (CLKS_PER_BIT=4):
  - START_EDGE=1: exactly one frame.
  - START_EDGE=0: consecutive 40-cycle frames separated by one idle cycle; data changed mid-frame appears only in the next frame.
- Busy start: a start pulse and data=8'hFF mid-frame are ignored; the frame completes unchanged and no second frame is sent.
- Reset mid-frame:
  - Assert reset during data bit 3: cereal=1, busy=0 asynchronously; no done pulse.
  - After release, a fresh start sends a clean full frame.
